// File: rtl/stack_pkg.sv
// Definitions shared by the operand stack and the register file: flush FSM states,
// the stack operand codes and the default data width.
package stack_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } stack_state_e;

  localparam logic [7:0] STACK_TOP_REG    = 8'b00100000;
  localparam logic [7:0] STACK_AMOUNT_REG = 8'b00100001;

  localparam int unsigned STACK_WIDTH = 32;

endpackage

// File: rtl/stack_flush_seq.sv
// Flush sequencer: walks every storage index once and zeroes it after reset or on request.
module stack_flush_seq
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             init,
  input  logic             start,
  output logic             busy,
  output logic             wr_en,
  output logic [PTR_W-1:0] idx
);

  localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

  stack_state_e     state_q, state_d;
  logic [PTR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clock) begin
    if (!init) begin
      state_q <= ST_FLUSH;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FLUSH;
          idx_d   = '0;
        end
      end
      ST_FLUSH: begin
        // A repeated request restarts the sweep rather than extending it.
        if (start) begin
          idx_d = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      default: begin
        state_d = ST_FLUSH;
        idx_d   = '0;
      end
    endcase
  end

  assign busy  = (state_q == ST_FLUSH);
  assign wr_en = busy;
  assign idx   = idx_q;

endmodule

// File: rtl/operand_stack.sv
// Hardware LIFO beside the register file: push from write-back, pop from decode,
// combinational top/amount views and sticky overflow/underflow flags.
module operand_stack
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = STACK_WIDTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             init,
  input  logic             STACK_push_flag,
  input  logic [WIDTH-1:0] STACK_push_value,
  input  logic             STACK_pop_flag,
  input  logic             STACK_flush,
  input  logic             err_clear,
  output logic [WIDTH-1:0] STACK_TOP,
  output logic [15:0]      STACK_AMOUNT,
  output logic             STACK_full,
  output logic             STACK_empty,
  output logic             STACK_busy,
  output logic             STACK_overflow,
  output logic             STACK_underflow
);

  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             mem_we;
  logic [PTR_W-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  logic             flush_busy;
  logic             flush_wr_en;
  logic [PTR_W-1:0] flush_idx;
  logic [PTR_W-1:0] top_idx;

  stack_flush_seq #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_flush_seq (
    .clock (clock),
    .init  (init),
    .start (STACK_flush),
    .busy  (flush_busy),
    .wr_en (flush_wr_en),
    .idx   (flush_idx)
  );

  // Low index bits minus one also gives DEPTH-1 when the stack is exactly full.
  assign top_idx = count_q[PTR_W-1:0] - IDX_ONE;

  always_comb begin
    count_d   = count_q;
    ovf_d     = ovf_q & ~err_clear;
    unf_d     = unf_q & ~err_clear;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (flush_busy) begin
      mem_we   = flush_wr_en;
      mem_addr = flush_idx;
      if (STACK_flush) begin
        count_d = '0;
      end
    end else if (STACK_flush) begin
      count_d = '0;
    end else begin
      unique case ({STACK_push_flag, STACK_pop_flag})
        2'b10: begin
          if (count_q == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_addr  = count_q[PTR_W-1:0];
            mem_wdata = STACK_push_value;
            count_d   = count_q + CNT_ONE;
          end
        end
        2'b01: begin
          if (count_q == '0) begin
            unf_d = 1'b1;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        2'b11: begin
          mem_we    = 1'b1;
          mem_wdata = STACK_push_value;
          if (count_q == '0) begin
            unf_d    = 1'b1;
            mem_addr = '0;
            count_d  = CNT_ONE;
          end else begin
            mem_addr = top_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!init) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (init && mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign STACK_TOP       = (count_q != '0) ? mem_q[top_idx] : '0;
  assign STACK_AMOUNT    = 16'(count_q);
  assign STACK_full      = (count_q == CNT_FULL);
  assign STACK_empty     = (count_q == '0);
  assign STACK_busy      = flush_busy;
  assign STACK_overflow  = ovf_q;
  assign STACK_underflow = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_operand_stack;

  localparam int DEPTH = 64;
  localparam int WIDTH = 32;

  logic             clock;
  logic             init;
  logic             STACK_push_flag;
  logic [WIDTH-1:0] STACK_push_value;
  logic             STACK_pop_flag;
  logic             STACK_flush;
  logic             err_clear;
  logic [WIDTH-1:0] STACK_TOP;
  logic [15:0]      STACK_AMOUNT;
  logic             STACK_full;
  logic             STACK_empty;
  logic             STACK_busy;
  logic             STACK_overflow;
  logic             STACK_underflow;

  operand_stack #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clock            (clock),
    .init             (init),
    .STACK_push_flag  (STACK_push_flag),
    .STACK_push_value (STACK_push_value),
    .STACK_pop_flag   (STACK_pop_flag),
    .STACK_flush      (STACK_flush),
    .err_clear        (err_clear),
    .STACK_TOP        (STACK_TOP),
    .STACK_AMOUNT     (STACK_AMOUNT),
    .STACK_full       (STACK_full),
    .STACK_empty      (STACK_empty),
    .STACK_busy       (STACK_busy),
    .STACK_overflow   (STACK_overflow),
    .STACK_underflow  (STACK_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf;
  bit               m_unf;
  int               m_busy;

  function automatic void model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_busy = DEPTH;
  endfunction

  function automatic void model_step(bit pu, bit po, bit fl, bit cl, logic [WIDTH-1:0] v);
    bit nov = 1'b0;
    bit nun = 1'b0;
    if (m_busy > 0) begin
      if (fl) m_busy = DEPTH;
      else    m_busy = m_busy - 1;
    end else if (fl) begin
      mq.delete();
      m_busy = DEPTH;
    end else if (pu && po) begin
      if (mq.size() == 0) begin
        nun = 1'b1;
        mq.push_back(v);
      end else begin
        mq[mq.size()-1] = v;
      end
    end else if (pu) begin
      if (mq.size() == DEPTH) nov = 1'b1;
      else                    mq.push_back(v);
    end else if (po) begin
      if (mq.size() == 0) nun = 1'b1;
      else                void'(mq.pop_back());
    end
    m_ovf = (m_ovf && !cl) || nov;
    m_unf = (m_unf && !cl) || nun;
  endfunction

  function automatic logic [WIDTH-1:0] model_top();
    if (mq.size() == 0) return '0;
    return mq[mq.size()-1];
  endfunction

  task automatic check_eq(string name, logic [WIDTH-1:0] got, logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    check_eq({tag, ".amount"},    WIDTH'(STACK_AMOUNT), WIDTH'(mq.size()));
    check_eq({tag, ".top"},       STACK_TOP, model_top());
    check_eq({tag, ".full"},      WIDTH'(STACK_full), WIDTH'(mq.size() == DEPTH));
    check_eq({tag, ".empty"},     WIDTH'(STACK_empty), WIDTH'(mq.size() == 0));
    check_eq({tag, ".busy"},      WIDTH'(STACK_busy), WIDTH'(m_busy > 0));
    check_eq({tag, ".overflow"},  WIDTH'(STACK_overflow), WIDTH'(m_ovf));
    check_eq({tag, ".underflow"}, WIDTH'(STACK_underflow), WIDTH'(m_unf));
  endtask

  // Called at a negedge: drive inputs, take one rising edge, sample at the next negedge.
  task automatic cycle(bit pu, bit po, bit fl, bit cl, logic [WIDTH-1:0] v, string tag);
    STACK_push_flag  = pu;
    STACK_pop_flag   = po;
    STACK_flush      = fl;
    err_clear        = cl;
    STACK_push_value = v;
    @(posedge clock);
    if (!init) model_reset();
    else       model_step(pu, po, fl, cl, v);
    @(negedge clock);
    check_model(tag);
  endtask

  // Counts cycles with STACK_busy high; optionally pushes on the first busy cycle.
  task automatic count_busy(string tag, bit push_first);
    int n = 0;
    while (STACK_busy && n < 200) begin
      cycle(push_first && n == 0, 1'b0, 1'b0, 1'b0, 32'h44, {tag, ".wait"});
      n++;
    end
    check_eq({tag, ".busy_cycles"}, WIDTH'(n), WIDTH'(DEPTH));
  endtask

  typedef struct {
    bit               push;
    bit               pop;
    bit               clr;
    logic [WIDTH-1:0] value;
    int               exp_amount;
    logic [WIDTH-1:0] exp_top;
    bit               exp_ovf;
    bit               exp_unf;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1, 0, 0, 32'h11, 1, 32'h11, 0, 0};
    vecs[1]  = '{1, 0, 0, 32'h22, 2, 32'h22, 0, 0};
    vecs[2]  = '{1, 0, 0, 32'h33, 3, 32'h33, 0, 0};
    vecs[3]  = '{0, 1, 0, 32'h0,  2, 32'h22, 0, 0};
    vecs[4]  = '{0, 1, 0, 32'h0,  1, 32'h11, 0, 0};
    vecs[5]  = '{0, 1, 0, 32'h0,  0, 32'h0,  0, 0};
    vecs[6]  = '{0, 1, 0, 32'h0,  0, 32'h0,  0, 1};
    vecs[7]  = '{1, 1, 0, 32'h5,  1, 32'h5,  0, 1};
    vecs[8]  = '{0, 0, 1, 32'h0,  1, 32'h5,  0, 0};
    vecs[9]  = '{1, 0, 0, 32'h22, 2, 32'h22, 0, 0};
    vecs[10] = '{1, 1, 0, 32'h99, 2, 32'h99, 0, 0};
    vecs[11] = '{0, 1, 0, 32'h0,  1, 32'h5,  0, 0};
    vecs[12] = '{0, 1, 0, 32'h0,  0, 32'h0,  0, 0};

    init             = 1'b0;
    STACK_push_flag  = 1'b0;
    STACK_pop_flag   = 1'b0;
    STACK_flush      = 1'b0;
    err_clear        = 1'b0;
    STACK_push_value = '0;
    model_reset();
    @(negedge clock);

    // Reset state
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, '0, "reset");
    check_eq("reset.busy_const", WIDTH'(STACK_busy), 32'd1);
    init = 1'b1;
    count_busy("post_reset", 1'b0);
    check_eq("post_reset.amount", WIDTH'(STACK_AMOUNT), 32'd0);
    check_eq("post_reset.empty", WIDTH'(STACK_empty), 32'd1);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].push, vecs[i].pop, 1'b0, vecs[i].clr, vecs[i].value, $sformatf("vec%0d", i));
      check_eq($sformatf("vec%0d.amount_tbl", i), WIDTH'(STACK_AMOUNT), WIDTH'(vecs[i].exp_amount));
      check_eq($sformatf("vec%0d.top_tbl", i), STACK_TOP, vecs[i].exp_top);
      check_eq($sformatf("vec%0d.ovf_tbl", i), WIDTH'(STACK_overflow), WIDTH'(vecs[i].exp_ovf));
      check_eq($sformatf("vec%0d.unf_tbl", i), WIDTH'(STACK_underflow), WIDTH'(vecs[i].exp_unf));
    end

    // Fill, overflow, replace-when-full, clear
    for (int i = 1; i <= DEPTH; i++) cycle(1, 0, 0, 0, WIDTH'(i), "fill");
    check_eq("fill.full", WIDTH'(STACK_full), 32'd1);
    check_eq("fill.top", STACK_TOP, 32'd64);
    cycle(1, 0, 0, 0, 32'hDEAD, "overflow");
    check_eq("overflow.flag", WIDTH'(STACK_overflow), 32'd1);
    check_eq("overflow.top", STACK_TOP, 32'd64);
    check_eq("overflow.amount", WIDTH'(STACK_AMOUNT), 32'd64);
    cycle(1, 1, 0, 0, 32'hAB, "full_replace");
    check_eq("full_replace.top", STACK_TOP, 32'hAB);
    check_eq("full_replace.amount", WIDTH'(STACK_AMOUNT), 32'd64);
    cycle(0, 0, 0, 1, '0, "err_clear");
    check_eq("err_clear.ovf", WIDTH'(STACK_overflow), 32'd0);
    cycle(1, 0, 0, 1, 32'hBEEF, "clr_and_set");
    check_eq("clr_and_set.ovf", WIDTH'(STACK_overflow), 32'd1);

    // Flush racing a push
    cycle(0, 0, 1, 0, '0, "flush_a");
    count_busy("flush_a", 1'b0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, WIDTH'(32'h100 + i), "refill");
    check_eq("refill.amount", WIDTH'(STACK_AMOUNT), 32'd5);
    cycle(1, 0, 1, 0, 32'h77, "flush_push");
    check_eq("flush_push.amount", WIDTH'(STACK_AMOUNT), 32'd0);
    check_eq("flush_push.busy", WIDTH'(STACK_busy), 32'd1);
    count_busy("flush_b", 1'b1);
    check_eq("flush_b.amount", WIDTH'(STACK_AMOUNT), 32'd0);
    cycle(1, 0, 0, 0, 32'h1, "after_flush");
    check_eq("after_flush.amount", WIDTH'(STACK_AMOUNT), 32'd1);
    check_eq("after_flush.top", STACK_TOP, 32'h1);

    // Flush restarted mid-sweep, then reset mid-sweep
    cycle(0, 0, 1, 0, '0, "restart");
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, '0, "restart.pre");
    cycle(0, 0, 1, 0, '0, "restart.again");
    count_busy("restart", 1'b0);
    cycle(0, 0, 1, 0, '0, "rst_mid");
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, '0, "rst_mid.pre");
    init = 1'b0;
    cycle(1, 0, 0, 0, 32'h55, "rst_mid.reset");
    init = 1'b1;
    count_busy("rst_mid", 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int  r     = int'($urandom_range(0, 99));
      int  bias  = (i < 1500) ? 65 : 35;
      bit  pu    = (r < bias);
      bit  po    = ($urandom_range(0, 99) < 45);
      bit  fl    = ($urandom_range(0, 299) == 0);
      bit  cl    = ($urandom_range(0, 15) == 0);
      cycle(pu, po, fl, cl, WIDTH'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
